// File: rtl/stall_control_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | stall_control_unit_pkg                                                     |
// | ISA field constants, FSM state type and decode helpers for the interlock. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package stall_control_unit_pkg;

  localparam logic [4:0] c_op_r    = 5'd0;
  localparam logic [4:0] c_op_j    = 5'd1;
  localparam logic [4:0] c_op_bne  = 5'd2;
  localparam logic [4:0] c_op_jal  = 5'd3;
  localparam logic [4:0] c_op_jr   = 5'd4;
  localparam logic [4:0] c_op_addi = 5'd5;
  localparam logic [4:0] c_op_blt  = 5'd6;
  localparam logic [4:0] c_op_sw   = 5'd7;
  localparam logic [4:0] c_op_lw   = 5'd8;
  localparam logic [4:0] c_op_setx = 5'd21;
  localparam logic [4:0] c_op_bex  = 5'd22;

  localparam logic [4:0] c_alu_mul = 5'b00110;
  localparam logic [4:0] c_alu_div = 5'b00111;

  localparam int c_cnt_w = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [4:0] f_opcode(input logic [31:0] instr);
    return instr[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[26:22];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[21:17];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[16:12];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] instr);
    return instr[6:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/stall_control_unit_src_reg_decode.sv
// +----------------------------------------------------------------------------+
// | src_reg_decode                                                             |
// | Extracts up to two source register numbers read by an instruction.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module src_reg_decode
  import stall_control_unit_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b,
  output logic        src_a_vld,
  output logic        src_b_vld
);

  logic [4:0] w_op;
  logic [4:0] w_rd;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_unused_bits;

  assign w_op = f_opcode(instr);
  assign w_rd = f_rd(instr);
  assign w_rs = f_rs(instr);
  assign w_rt = f_rt(instr);
  assign w_unused_bits = &{1'b0, instr[11:0]};

  // Branches compare rd against rs, so rd is a source for bne/blt/jr.
  always_comb begin
    src_a     = 5'd0;
    src_b     = 5'd0;
    src_a_vld = 1'b0;
    src_b_vld = 1'b0;
    case (w_op)
      c_op_r: begin
        src_a     = w_rs;
        src_b     = w_rt;
        src_a_vld = 1'b1;
        src_b_vld = 1'b1;
      end
      c_op_addi, c_op_lw, c_op_sw: begin
        src_a     = w_rs;
        src_a_vld = 1'b1;
      end
      c_op_bne, c_op_blt: begin
        src_a     = w_rd;
        src_b     = w_rs;
        src_a_vld = 1'b1;
        src_b_vld = 1'b1;
      end
      c_op_jr: begin
        src_a     = w_rd;
        src_a_vld = 1'b1;
      end
      default: begin
        src_a_vld = 1'b0;
        src_b_vld = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stall_control_unit.sv
// +----------------------------------------------------------------------------+
// | stall_control_unit                                                         |
// | Pipeline interlock: load-use stall, mul/div sequencing, branch flush.     |
// | Optional watchdog on multdiv BUSY: MULTDIV_TIMEOUT_EN                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module stall_control_unit
  import stall_control_unit_pkg::*;
`ifdef MULTDIV_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 40
)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FD_Latch_Instr,
  input  logic [31:0] DX_Latch_Instr,
  input  logic        branch_taken,
  input  logic        multdiv_resultRDY,
  input  logic        multdiv_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        PC_enable,
  output logic        FD_enable,
  output logic        DX_enable,
  output logic        FD_flush,
  output logic        DX_bubble,
  output logic        XM_bubble,
  output logic        multdiv_capture,
  output logic        multdiv_error
);

  state_t             r_state;
  state_t             w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_exc;

  logic [4:0] w_dx_op;
  logic [4:0] w_dx_rd;
  logic [4:0] w_dx_alu;
  logic       w_dx_is_mul;
  logic       w_dx_is_div;
  logic       w_dx_muldiv;
  logic       w_unused_bits;

  logic [4:0] w_fd_src_a;
  logic [4:0] w_fd_src_b;
  logic       w_fd_src_a_vld;
  logic       w_fd_src_b_vld;

  logic w_load_use;
  logic w_start;
  logic w_hold;
  logic w_rdy_accept;
  logic w_timeout;

  assign w_dx_op       = f_opcode(DX_Latch_Instr);
  assign w_dx_rd       = f_rd(DX_Latch_Instr);
  assign w_dx_alu      = f_aluop(DX_Latch_Instr);
  assign w_dx_is_mul   = (w_dx_op == c_op_r) && (w_dx_alu == c_alu_mul);
  assign w_dx_is_div   = (w_dx_op == c_op_r) && (w_dx_alu == c_alu_div);
  assign w_dx_muldiv   = w_dx_is_mul || w_dx_is_div;
  assign w_unused_bits = &{1'b0, DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

  src_reg_decode u_src_reg_decode (
    .instr     (FD_Latch_Instr),
    .src_a     (w_fd_src_a),
    .src_b     (w_fd_src_b),
    .src_a_vld (w_fd_src_a_vld),
    .src_b_vld (w_fd_src_b_vld)
  );

  // r0 is hard-wired zero, so a load into it never creates a dependency.
  assign w_load_use = (w_dx_op == c_op_lw) && (w_dx_rd != 5'd0) &&
                      ((w_fd_src_a_vld && (w_fd_src_a == w_dx_rd)) ||
                       (w_fd_src_b_vld && (w_fd_src_b == w_dx_rd)));

  assign w_start      = (r_state == S_IDLE) && w_dx_muldiv;
  assign w_hold       = w_start || (r_state == S_BUSY);
  assign w_rdy_accept = (r_state == S_BUSY) && multdiv_resultRDY;

`ifdef MULTDIV_TIMEOUT_EN
  assign w_timeout = (r_state == S_BUSY) && !multdiv_resultRDY &&
                     (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_cnt <= '0;
      end else if ((r_state == S_BUSY) && (r_cnt != {c_cnt_w{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rdy_accept) begin
        r_exc <= multdiv_exception;
      end else if (w_timeout) begin
        r_exc <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state    = r_state;
    ctrl_MULT       = 1'b0;
    ctrl_DIV        = 1'b0;
    PC_enable       = 1'b1;
    FD_enable       = 1'b1;
    DX_enable       = 1'b1;
    FD_flush        = 1'b0;
    DX_bubble       = 1'b0;
    XM_bubble       = 1'b0;
    multdiv_capture = 1'b0;
    multdiv_error   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_dx_muldiv) begin
          w_next_state = S_BUSY;
          // Start pulses stay low while reset is held so nothing launches early.
          ctrl_MULT    = w_dx_is_mul && !reset;
          ctrl_DIV     = w_dx_is_div && !reset;
        end
      end
      S_BUSY: begin
        if (w_rdy_accept || w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        multdiv_capture = 1'b1;
        multdiv_error   = r_exc;
        w_next_state    = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (w_hold) begin
      PC_enable = 1'b0;
      FD_enable = 1'b0;
      DX_enable = 1'b0;
      XM_bubble = 1'b1;
    end else if (branch_taken) begin
      FD_flush  = 1'b1;
      DX_bubble = 1'b1;
      PC_enable = 1'b1;
    end else if (w_load_use) begin
      PC_enable = 1'b0;
      FD_enable = 1'b0;
      DX_bubble = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stall_control_unit.sv
// +----------------------------------------------------------------------------+
// | tb_stall_control_unit                                                      |
// | Vector table, directed mul/div sequences and random run vs. a model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stall_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_instr;
  logic [31:0] dx_instr;
  logic        branch_taken;
  logic        rdy;
  logic        exc_in;
  logic        ctrl_MULT, ctrl_DIV, PC_enable, FD_enable, DX_enable;
  logic        FD_flush, DX_bubble, XM_bubble, multdiv_capture, multdiv_error;
  logic [9:0]  dut_out;

  int checks   = 0;
  int failures = 0;

  // Model: a transaction is either in flight (waiting on multdiv) or
  // finishing (capture cycle); busy counts waiting cycles.
  bit m_inflight, m_done, m_exc;
  int m_busy;

  stall_control_unit dut (
    .clock             (clock),
    .reset             (reset),
    .FD_Latch_Instr    (fd_instr),
    .DX_Latch_Instr    (dx_instr),
    .branch_taken      (branch_taken),
    .multdiv_resultRDY (rdy),
    .multdiv_exception (exc_in),
    .ctrl_MULT         (ctrl_MULT),
    .ctrl_DIV          (ctrl_DIV),
    .PC_enable         (PC_enable),
    .FD_enable         (FD_enable),
    .DX_enable         (DX_enable),
    .FD_flush          (FD_flush),
    .DX_bubble         (DX_bubble),
    .XM_bubble         (XM_bubble),
    .multdiv_capture   (multdiv_capture),
    .multdiv_error     (multdiv_error)
  );

  assign dut_out = {ctrl_MULT, ctrl_DIV, PC_enable, FD_enable, DX_enable,
                    FD_flush, DX_bubble, XM_bubble, multdiv_capture, multdiv_error};

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(int op, int rd, int rs, int rt, int alu);
    logic [31:0] v;
    v = '0;
    v[31:27] = op[4:0];
    v[26:22] = rd[4:0];
    v[21:17] = rs[4:0];
    v[16:12] = rt[4:0];
    v[6:2]   = alu[4:0];
    return v;
  endfunction

  // Set of architectural registers the instruction reads, as a bitmask.
  function automatic logic [31:0] reads_mask(logic [31:0] ins);
    int op = int'(ins[31:27]);
    int rd = int'(ins[26:22]);
    int rs = int'(ins[21:17]);
    int rt = int'(ins[16:12]);
    logic [31:0] m;
    m = '0;
    case (op)
      0:       begin m[rs] = 1'b1; m[rt] = 1'b1; end
      5, 7, 8: m[rs] = 1'b1;
      2, 6:    begin m[rd] = 1'b1; m[rs] = 1'b1; end
      4:       m[rd] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // 0 = neither, 1 = mul, 2 = div
  function automatic int md_kind(logic [31:0] ins);
    if (ins[31:27] != 5'd0) return 0;
    if (ins[6:2] == 5'd6) return 1;
    if (ins[6:2] == 5'd7) return 2;
    return 0;
  endfunction

  function automatic logic [9:0] model_out();
    int k = md_kind(dx_instr);
    bit start, hold;
    logic [31:0] rm;
    int rd;
    logic cm = 0, cd = 0, pc = 1, fe = 1, de = 1, fl = 0, db = 0, xb = 0, cap = 0, er = 0;
    start = !m_inflight && !m_done && (k != 0);
    hold  = m_inflight || start;
    rm    = reads_mask(fd_instr);
    rd    = int'(dx_instr[26:22]);
    if (m_done) begin cap = 1; er = m_exc; end
    if (start && !reset) begin cm = (k == 1); cd = (k == 2); end
    if (hold) begin
      pc = 0; fe = 0; de = 0; xb = 1;
    end else if (branch_taken) begin
      fl = 1; db = 1;
    end else if (dx_instr[31:27] == 5'd8 && rd != 0 && rm[rd]) begin
      pc = 0; fe = 0; db = 1;
    end
    return {cm, cd, pc, fe, de, fl, db, xb, cap, er};
  endfunction

  task automatic model_update();
    int k = md_kind(dx_instr);
    if (reset) begin
      m_inflight = 0; m_done = 0; m_exc = 0; m_busy = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_inflight) begin
      m_busy++;
      if (rdy) begin
        m_inflight = 0; m_done = 1; m_exc = exc_in;
      end
`ifdef MULTDIV_TIMEOUT_EN
      else if (m_busy >= 40) begin
        m_inflight = 0; m_done = 1; m_exc = 1;
      end
`endif
    end else if (k != 0) begin
      m_inflight = 1; m_busy = 0;
    end
  endtask

  task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic sample(string tag);
    @(negedge clock);
    chk({tag, "_model"}, dut_out, model_out());
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int sel = int'($urandom_range(0, 7));
    int a = int'($urandom_range(0, 7));
    int b = int'($urandom_range(0, 7));
    int c = int'($urandom_range(0, 7));
    case (sel)
      0, 1: return mk(8, a, b, 0, 0);
      2:    return mk(0, a, b, c, 0);
      3:    return mk(0, a, b, c, 6);
      4:    return mk(0, a, b, c, 7);
      5:    return mk(5, a, b, 0, 0);
      6:    return mk(($urandom_range(0, 1) != 0) ? 2 : 6, a, b, 0, 0);
      default: begin
        case ($urandom_range(0, 5))
          0: return mk(1, a, b, c, 0);
          1: return mk(3, a, b, c, 0);
          2: return mk(4, a, b, c, 0);
          3: return mk(21, a, b, c, 0);
          4: return mk(22, a, b, c, 0);
          default: return mk(7, a, b, 0, 0);
        endcase
      end
    endcase
  endfunction

  typedef struct {
    logic [31:0] dx;
    logic [31:0] fd;
    logic        br;
    logic [3:0]  exp;   // {PC_enable, FD_enable, FD_flush, DX_bubble}
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [31:0] lw5, nop, mul_i, div_i;
    lw5   = mk(8, 5, 2, 0, 0);
    nop   = 32'd0;
    mul_i = mk(0, 3, 1, 2, 6);
    div_i = mk(0, 4, 1, 2, 7);

    vt[0]  = '{lw5,             mk(0, 6, 5, 2, 0),  1'b0, 4'b0001};
    vt[1]  = '{mk(8, 0, 2, 0, 0), mk(0, 6, 0, 0, 0), 1'b0, 4'b1100};
    vt[2]  = '{lw5,             mk(1, 5, 5, 5, 0),  1'b0, 4'b1100};
    vt[3]  = '{lw5,             mk(0, 6, 2, 5, 0),  1'b0, 4'b0001};
    vt[4]  = '{lw5,             mk(5, 7, 5, 0, 0),  1'b0, 4'b0001};
    vt[5]  = '{lw5,             mk(7, 5, 3, 0, 0),  1'b0, 4'b1100};
    vt[6]  = '{lw5,             mk(2, 5, 1, 0, 0),  1'b0, 4'b0001};
    vt[7]  = '{lw5,             mk(6, 1, 5, 0, 0),  1'b0, 4'b0001};
    vt[8]  = '{lw5,             mk(4, 5, 0, 0, 0),  1'b0, 4'b0001};
    vt[9]  = '{lw5,             mk(0, 6, 5, 2, 0),  1'b1, 4'b1111};
    vt[10] = '{mk(0, 5, 1, 2, 0), mk(0, 6, 5, 5, 0), 1'b0, 4'b1100};
    vt[11] = '{lw5,             mk(22, 5, 5, 5, 0), 1'b0, 4'b1100};
    vt[12] = '{lw5,             mk(3, 5, 5, 5, 0),  1'b0, 4'b1100};
    vt[13] = '{nop,             nop,                1'b1, 4'b1111};
    vt[14] = '{lw5,             mk(8, 9, 5, 0, 0),  1'b0, 4'b0001};
    vt[15] = '{lw5,             mk(21, 5, 5, 5, 0), 1'b0, 4'b1100};

    m_inflight = 0; m_done = 0; m_exc = 0; m_busy = 0;
    reset = 1'b1; fd_instr = nop; dx_instr = nop;
    branch_taken = 1'b0; rdy = 1'b0; exc_in = 1'b0;

    #1;
    sample("reset0");
    chk("reset_outputs", dut_out, 10'b0011100000);
    advance();
    sample("reset1");
    advance();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      dx_instr = vt[i].dx; fd_instr = vt[i].fd; branch_taken = vt[i].br;
      sample($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ctl", i),
          {6'd0, PC_enable, FD_enable, FD_flush, DX_bubble}, {6'd0, vt[i].exp});
      advance();
    end
    branch_taken = 1'b0;

    // load-use for one cycle, then the bubble is in DX and the stall clears
    dx_instr = lw5; fd_instr = mk(0, 6, 5, 2, 0);
    sample("lu_c1");
    chk("lu_stall", {8'd0, PC_enable, DX_bubble}, 10'b01);
    advance();
    dx_instr = nop;
    sample("lu_c2");
    chk("lu_release", {8'd0, PC_enable, DX_bubble}, 10'b10);
    advance();
    fd_instr = nop;

    // mul with result 32 BUSY cycles after start
    dx_instr = mul_i;
    sample("mul_start");
    chk("mul_start_pulse", {6'd0, ctrl_MULT, ctrl_DIV, XM_bubble, PC_enable}, 10'b1010);
    advance();
    for (int i = 1; i <= 32; i++) begin
      rdy = (i == 32);
      sample("mul_busy");
      chk($sformatf("mul_busy%0d", i),
          {6'd0, ctrl_MULT, XM_bubble, PC_enable, multdiv_capture}, 10'b0100);
      advance();
    end
    rdy = 1'b0;
    sample("mul_done");
    chk("mul_capture",
        {4'd0, multdiv_capture, multdiv_error, XM_bubble, PC_enable, FD_enable, DX_enable},
        10'b100111);
    advance();

    // div with exception, immediately followed by mul
    dx_instr = div_i;
    sample("div_start");
    chk("div_start_pulse", {8'd0, ctrl_MULT, ctrl_DIV}, 10'b01);
    advance();
    for (int i = 1; i <= 5; i++) begin
      rdy = (i == 5); exc_in = (i == 5);
      sample("div_busy");
      advance();
    end
    rdy = 1'b0; exc_in = 1'b0;
    sample("div_done");
    chk("div_capture_err", {8'd0, multdiv_capture, multdiv_error}, 10'b11);
    advance();
    dx_instr = mul_i;
    sample("b2b_mul");
    chk("b2b_restart", {8'd0, ctrl_MULT, multdiv_capture}, 10'b10);
    advance();
    for (int i = 1; i <= 3; i++) begin
      rdy = (i == 3);
      sample("b2b_busy");
      advance();
    end
    rdy = 1'b0;
    sample("b2b_done");
    chk("b2b_capture", {8'd0, multdiv_capture, multdiv_error}, 10'b10);
    advance();

    // reset in the 10th BUSY cycle: no capture, instruction restarts
    dx_instr = mul_i;
    sample("rst_start");
    advance();
    for (int i = 1; i <= 9; i++) begin
      sample("rst_busy");
      advance();
    end
    reset = 1'b1;
    sample("rst_assert");
    chk("rst_no_pulse", {8'd0, ctrl_MULT, multdiv_capture}, 10'b00);
    advance();
    reset = 1'b0;
    sample("rst_restart");
    chk("rst_restart", {7'd0, ctrl_MULT, multdiv_capture, XM_bubble}, 10'b101);
    advance();
    rdy = 1'b1;
    sample("rst_busy2");
    advance();
    rdy = 1'b0;
    sample("rst_done");
    chk("rst_capture", {8'd0, multdiv_capture, multdiv_error}, 10'b10);
    advance();

    // no result from multdiv
    dx_instr = div_i;
    sample("to_start");
    advance();
`ifdef MULTDIV_TIMEOUT_EN
    for (int i = 1; i <= 40; i++) begin
      sample("to_busy");
      advance();
    end
    sample("to_done");
    chk("timeout_capture", {8'd0, multdiv_capture, multdiv_error}, 10'b11);
    advance();
`else
    for (int i = 1; i <= 60; i++) begin
      sample("to_busy");
      advance();
    end
    sample("to_wait");
    chk("no_timeout_hold", {8'd0, multdiv_capture, XM_bubble}, 10'b01);
    rdy = 1'b1;
    advance();
    rdy = 1'b0;
    sample("to_done");
    chk("late_capture", {8'd0, multdiv_capture, multdiv_error}, 10'b10);
    advance();
`endif
    dx_instr = nop;

    // randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!m_inflight && !m_done) dx_instr = rand_instr();
      fd_instr     = rand_instr();
      branch_taken = ($urandom_range(0, 5) == 0);
      rdy          = ($urandom_range(0, 4) == 0);
      exc_in       = ($urandom_range(0, 1) != 0);
      sample("rand");
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
